// File: rtl/param_ram_pkg.sv
// ---------------------------------------------------------------------------
// param_ram_pkg
// Shared types and helpers for the parameter RAM block.
//   state_t     : init sequencer state encoding (IDLE, INIT)
//   addr_width  : address width for a given word count, ceil(log2(depth)),
//                 never less than one bit
// ---------------------------------------------------------------------------
package param_ram_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } state_t;

   function automatic int addr_width(input int depth);
      int w;
      w = 1;
      while ((1 << w) < depth) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/param_ram_init_seq.sv
// ---------------------------------------------------------------------------
// param_ram_init_seq
// Init sequencer for param_ram. On an init request it walks every word index
// in ascending order, one per cycle, and supplies the preset value for that
// word. While busy is high the top writes init_data into word init_idx.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   init_req   in   start request, honoured only in IDLE
//   state      out  current sequencer state
//   busy       out  high for exactly DEPTH cycles per init sequence
//   init_idx   out  word index being preset this cycle
//   init_data  out  preset value, (INIT_BASE + init_idx) mod 2^DATA_W
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; accesses allowed in the top, init_req starts INIT
// INIT  | presetting word init_idx; init_req ignored; leaves after DEPTH-1
// ---------------------------------------------------------------------------
module param_ram_init_seq
   import param_ram_pkg::*;
#(
   parameter  int DATA_W    = 4,
   parameter  int DEPTH     = 8,
   parameter  int INIT_BASE = 2,
   localparam int ADDR_W    = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   output state_t            state,
   output logic              busy,
   output logic [ADDR_W-1:0] init_idx,
   output logic [DATA_W-1:0] init_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic              last_word;

   assign last_word = (idx_q == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (init_req) begin
               state_d = INIT;
               idx_d   = '0;
            end
         end
         INIT: begin
            if (last_word) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign state    = state_q;
   assign busy     = (state_q == INIT);
   assign init_idx = idx_q;

   // Summing in DATA_W bits gives the mod 2^DATA_W wrap directly.
   assign init_data = DATA_W'(INIT_BASE) + DATA_W'(idx_q);

endmodule

// File: rtl/param_ram.sv
// ---------------------------------------------------------------------------
// param_ram
// Small single-port parameter RAM with bit-masked writes, registered reads,
// out-of-range detection and a hardware preset sequence.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset (memory is not cleared)
//   init_req  in   start a preset of every word
//   en        in   access strobe, one access per cycle
//   wr        in   1 = write, 0 = read
//   addr      in   word address
//   data_in   in   write data
//   wr_mask   in   per-bit write enable, 1 = bit updated
//   data_out  out  registered read data, held until the next valid read
//   rd_valid  out  one-cycle pulse with each new read result
//   busy      out  high while the preset sequence runs
//   addr_err  out  one-cycle pulse after an access to a word >= DEPTH
// ---------------------------------------------------------------------------
module param_ram
   import param_ram_pkg::*;
#(
   parameter  int DATA_W    = 4,
   parameter  int DEPTH     = 8,
   parameter  int INIT_BASE = 2,
   localparam int ADDR_W    = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] wr_mask,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              addr_err
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   logic              seq_busy;
   logic [ADDR_W-1:0] init_idx;
   logic [DATA_W-1:0] init_data;

   logic              in_range;
   logic              acc_ok;
   logic              do_write;
   logic              do_read;
   logic              do_err;

   param_ram_init_seq #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .INIT_BASE (INIT_BASE)
   ) u_init_seq (
      .clk       (clk),
      .rst       (rst),
      .init_req  (init_req),
      .state     (state),
      .busy      (seq_busy),
      .init_idx  (init_idx),
      .init_data (init_data)
   );

   assign busy = seq_busy;

   // DEPTH need not be a power of two, so the address can overshoot the array.
   assign in_range = (32'(addr) < DEPTH_U);

   // An init request in IDLE takes priority and swallows a same-cycle access;
   // nothing is accepted while reset is held.
   assign acc_ok   = en && (state == IDLE) && !init_req && !rst;
   assign do_write = acc_ok &&  wr && in_range;
   assign do_read  = acc_ok && !wr && in_range;
   assign do_err   = acc_ok && !in_range;

   // Memory carries no reset so its contents survive rst and an aborted init.
   always_ff @(posedge clk) begin
      if (seq_busy) begin
         mem[init_idx] <= init_data;
      end else if (do_write) begin
         mem[addr] <= (mem[addr] & ~wr_mask) | (data_in & wr_mask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rd_valid <= do_read;
         addr_err <= do_err;
         if (do_read) begin
            data_out <= mem[addr];
         end
      end
   end

endmodule

// File: tb/tb_param_ram.sv
// ---------------------------------------------------------------------------
// tb_param_ram
// Bench for param_ram: default instance (4/8/2) driven from a vector table
// plus hand sequences, a DEPTH=6 instance for out-of-range handling and a
// DEPTH=16, INIT_BASE=10 instance for preset wrap-around.
// ---------------------------------------------------------------------------
module tb_param_ram;

   logic clk;
   logic rst;

   // default instance
   logic       init_req0, en0, wr0;
   logic [2:0] addr0;
   logic [3:0] din0, mask0, do0;
   logic       rv0, busy0, ae0;

   // DEPTH = 6
   logic       init_req6, en6, wr6;
   logic [2:0] addr6;
   logic [3:0] din6, mask6, do6;
   logic       rv6, busy6, ae6;

   // DEPTH = 16, INIT_BASE = 10
   logic       init_req16, en16, wr16;
   logic [3:0] addr16;
   logic [3:0] din16, mask16, do16;
   logic       rv16, busy16, ae16;

   int tests;
   int fails;

   typedef struct {
      logic       en;
      logic       wr;
      logic [2:0] addr;
      logic [3:0] din;
      logic [3:0] mask;
      logic       exp_rv;
      logic [3:0] exp_do;
      logic       exp_ae;
   } vec_t;

   vec_t tbl [26];

   param_ram u0 (
      .clk(clk), .rst(rst), .init_req(init_req0), .en(en0), .wr(wr0),
      .addr(addr0), .data_in(din0), .wr_mask(mask0), .data_out(do0),
      .rd_valid(rv0), .busy(busy0), .addr_err(ae0)
   );

   param_ram #(.DATA_W(4), .DEPTH(6), .INIT_BASE(2)) u6 (
      .clk(clk), .rst(rst), .init_req(init_req6), .en(en6), .wr(wr6),
      .addr(addr6), .data_in(din6), .wr_mask(mask6), .data_out(do6),
      .rd_valid(rv6), .busy(busy6), .addr_err(ae6)
   );

   param_ram #(.DATA_W(4), .DEPTH(16), .INIT_BASE(10)) u16 (
      .clk(clk), .rst(rst), .init_req(init_req16), .en(en16), .wr(wr16),
      .addr(addr16), .data_in(din16), .wr_mask(mask16), .data_out(do16),
      .rd_valid(rv16), .busy(busy16), .addr_err(ae16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic wr, input logic [2:0] a,
                               input logic [3:0] d, input logic [3:0] m,
                               input logic rv, input logic [3:0] dout, input logic ae);
      vec_t v;
      v.en = en; v.wr = wr; v.addr = a; v.din = d; v.mask = m;
      v.exp_rv = rv; v.exp_do = dout; v.exp_ae = ae;
      return v;
   endfunction

   // Drive one access on u0 at the falling edge, sample after the next rise.
   task automatic step0(input logic en, input logic wr, input logic [2:0] a,
                        input logic [3:0] d, input logic [3:0] m);
      @(negedge clk);
      en0 = en; wr0 = wr; addr0 = a; din0 = d; mask0 = m;
      @(posedge clk);
      #1;
   endtask

   task automatic step6(input logic en, input logic wr, input logic [2:0] a,
                        input logic [3:0] d, input logic [3:0] m);
      @(negedge clk);
      en6 = en; wr6 = wr; addr6 = a; din6 = d; mask6 = m;
      @(posedge clk);
      #1;
   endtask

   task automatic read16(input logic [3:0] a);
      @(negedge clk);
      en16 = 1'b1; wr16 = 1'b0; addr16 = a;
      @(posedge clk);
      #1;
      en16 = 1'b0;
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         step0(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].mask);
         chk($sformatf("vec%0d rd_valid", i), 32'(rv0), 32'(tbl[i].exp_rv));
         chk($sformatf("vec%0d data_out", i), 32'(do0), 32'(tbl[i].exp_do));
         chk($sformatf("vec%0d addr_err", i), 32'(ae0), 32'(tbl[i].exp_ae));
      end
      @(negedge clk);
      en0 = 1'b0;
   endtask

   // Pulse init_req on u0 for one cycle and count busy-high cycles.
   task automatic init0(output int n);
      @(negedge clk);
      init_req0 = 1'b1;
      @(posedge clk);
      #1;
      init_req0 = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy0) n++;
         else break;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic init6(output int n);
      @(negedge clk);
      init_req6 = 1'b1;
      @(posedge clk);
      #1;
      init_req6 = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy6) n++;
         else break;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic init16(output int n);
      @(negedge clk);
      init_req16 = 1'b1;
      @(posedge clk);
      #1;
      init_req16 = 1'b0;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         if (busy16) n++;
         else break;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int  n;
      logic saw;

      tests = 0;
      fails = 0;

      // 0..7  : readback after aborted init (pre-init values were 15-i)
      tbl[0]  = mk(1, 0, 3'd0, 4'h0, 4'h0, 1, 4'd2,  0);
      tbl[1]  = mk(1, 0, 3'd1, 4'h0, 4'h0, 1, 4'd3,  0);
      tbl[2]  = mk(1, 0, 3'd2, 4'h0, 4'h0, 1, 4'd4,  0);
      tbl[3]  = mk(1, 0, 3'd3, 4'h0, 4'h0, 1, 4'd12, 0);
      tbl[4]  = mk(1, 0, 3'd4, 4'h0, 4'h0, 1, 4'd11, 0);
      tbl[5]  = mk(1, 0, 3'd5, 4'h0, 4'h0, 1, 4'd10, 0);
      tbl[6]  = mk(1, 0, 3'd6, 4'h0, 4'h0, 1, 4'd9,  0);
      tbl[7]  = mk(1, 0, 3'd7, 4'h0, 4'h0, 1, 4'd8,  0);
      // 8..15 : back-to-back reads after a full init
      tbl[8]  = mk(1, 0, 3'd0, 4'h0, 4'h0, 1, 4'd2,  0);
      tbl[9]  = mk(1, 0, 3'd1, 4'h0, 4'h0, 1, 4'd3,  0);
      tbl[10] = mk(1, 0, 3'd2, 4'h0, 4'h0, 1, 4'd4,  0);
      tbl[11] = mk(1, 0, 3'd3, 4'h0, 4'h0, 1, 4'd5,  0);
      tbl[12] = mk(1, 0, 3'd4, 4'h0, 4'h0, 1, 4'd6,  0);
      tbl[13] = mk(1, 0, 3'd5, 4'h0, 4'h0, 1, 4'd7,  0);
      tbl[14] = mk(1, 0, 3'd6, 4'h0, 4'h0, 1, 4'd8,  0);
      tbl[15] = mk(1, 0, 3'd7, 4'h0, 4'h0, 1, 4'd9,  0);
      // 16..25: masked writes and read-after-write
      tbl[16] = mk(1, 1, 3'd3, 4'hA, 4'b0011, 0, 4'd9,    0);
      tbl[17] = mk(1, 0, 3'd3, 4'h0, 4'h0,    1, 4'b0110, 0);
      tbl[18] = mk(1, 0, 3'd0, 4'h0, 4'h0,    1, 4'd2,    0);
      tbl[19] = mk(1, 1, 3'd1, 4'h0, 4'hF,    0, 4'd2,    0);
      tbl[20] = mk(1, 0, 3'd1, 4'h0, 4'h0,    1, 4'd0,    0);
      tbl[21] = mk(0, 0, 3'd1, 4'h0, 4'h0,    0, 4'd0,    0);
      tbl[22] = mk(1, 1, 3'd5, 4'h9, 4'b1000, 0, 4'd0,    0);
      tbl[23] = mk(1, 0, 3'd5, 4'h0, 4'h0,    1, 4'hF,    0);
      tbl[24] = mk(1, 1, 3'd7, 4'h5, 4'b0000, 0, 4'hF,    0);
      tbl[25] = mk(1, 0, 3'd7, 4'h0, 4'h0,    1, 4'd9,    0);

      rst = 1'b1;
      init_req0 = 0; en0 = 0; wr0 = 0; addr0 = 0; din0 = 0; mask0 = 0;
      init_req6 = 0; en6 = 0; wr6 = 0; addr6 = 0; din6 = 0; mask6 = 0;
      init_req16 = 0; en16 = 0; wr16 = 0; addr16 = 0; din16 = 0; mask16 = 0;
      #1;
      chk("reset data_out", 32'(do0), 32'h0);
      chk("reset rd_valid", 32'(rv0), 32'h0);
      chk("reset busy",     32'(busy0), 32'h0);
      chk("reset addr_err", 32'(ae0), 32'h0);

      @(negedge clk);
      rst = 1'b0;

      // known pre-init contents: word i = 15 - i
      for (int i = 0; i < 8; i++) begin
         step0(1'b1, 1'b1, 3'(i), 4'(15 - i), 4'hF);
      end
      @(negedge clk);
      en0 = 1'b0;

      // reset after three preset words
      @(negedge clk);
      init_req0 = 1'b1;
      @(posedge clk);
      #1;
      init_req0 = 1'b0;
      chk("abort busy start", 32'(busy0), 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort busy after rst", 32'(busy0), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      apply(0, 7);

      // full init: busy exactly 8 cycles, then preset readback
      init0(n);
      chk("init busy cycles", 32'(n), 32'd8);
      apply(8, 15);
      apply(16, 25);

      // init_req with a write to word 0, repeated init_req and reads during INIT
      @(negedge clk);
      init_req0 = 1'b1; en0 = 1'b1; wr0 = 1'b1; addr0 = 3'd0; din0 = 4'h0; mask0 = 4'hF;
      @(posedge clk);
      #1;
      chk("init+en rd_valid", 32'(rv0), 32'h0);
      chk("init+en addr_err", 32'(ae0), 32'h0);
      wr0 = 1'b0; addr0 = 3'd7;
      n = 0;
      saw = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (rv0 || ae0) saw = 1'b1;
         if (busy0) n++;
         else break;
         @(posedge clk);
         #1;
         if (k == 2) begin
            init_req0 = 1'b0;
            en0 = 1'b0;
         end
      end
      chk("retrigger busy cycles", 32'(n), 32'd8);
      chk("no output during init", 32'(saw), 32'h0);
      step0(1'b1, 1'b0, 3'd0, 4'h0, 4'h0);
      chk("word0 after dropped write", 32'(do0), 32'd2);
      chk("word0 rd_valid", 32'(rv0), 32'h1);
      @(negedge clk);
      en0 = 1'b0;

      // DEPTH = 6 out-of-range handling
      init6(n);
      chk("d6 busy cycles", 32'(n), 32'd6);
      step6(1'b1, 1'b0, 3'd2, 4'h0, 4'h0);
      chk("d6 read2", 32'(do6), 32'd4);
      step6(1'b1, 1'b0, 3'd7, 4'h0, 4'h0);
      chk("d6 oob read addr_err", 32'(ae6), 32'h1);
      chk("d6 oob read rd_valid", 32'(rv6), 32'h0);
      chk("d6 oob read data_out", 32'(do6), 32'd4);
      step6(1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
      chk("d6 addr_err one pulse", 32'(ae6), 32'h0);
      step6(1'b1, 1'b1, 3'd6, 4'h0, 4'hF);
      chk("d6 oob write addr_err", 32'(ae6), 32'h1);
      chk("d6 oob write data_out", 32'(do6), 32'd4);
      for (int i = 0; i < 6; i++) begin
         step6(1'b1, 1'b0, 3'(i), 4'h0, 4'h0);
         chk($sformatf("d6 word%0d", i), 32'(do6), 32'(i + 2));
         chk($sformatf("d6 word%0d ae", i), 32'(ae6), 32'h0);
      end
      @(negedge clk);
      en6 = 1'b0;

      // DEPTH = 16, INIT_BASE = 10 wrap-around
      init16(n);
      chk("d16 busy cycles", 32'(n), 32'd16);
      read16(4'd6);
      chk("d16 word6 wrap", 32'(do16), 32'd0);
      read16(4'd15);
      chk("d16 word15", 32'(do16), 32'd9);
      read16(4'd0);
      chk("d16 word0", 32'(do16), 32'd10);
      read16(4'd5);
      chk("d16 word5", 32'(do16), 32'd15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter: DATA_W, default 4, data word width in bits (>=1).
REQ-002 Parameter: DEPTH, default 8, number of words (>=2, need not be a power of two).
REQ-003 Parameter: INIT_BASE, default 2, preset value written to word 0 during init.
REQ-004 Derived constant: ADDR_W = ceil(log2(DEPTH)), not user-overridable.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 init_req  input  1  request preset of all words; sampled high for one cycle.
REQ-008 en  input  1  access strobe; one access per cycle when high.
REQ-009 wr  input  1  access type when en=1: 1 = write, 0 = read.
REQ-010 addr  input  ADDR_W  word address.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 wr_mask  input  DATA_W  per-bit write enable; 1 = bit updated.
REQ-013 data_out  output  DATA_W  registered read data.
REQ-014 rd_valid  output  1  one-cycle pulse; data_out holds a new read result.
REQ-015 busy  output  1  high while the init sequence runs.
REQ-016 addr_err  output  1  one-cycle pulse; the previous access addressed a word >= DEPTH.

Function
REQ-017 FSM states: IDLE, INIT; only IDLE accepts accesses.
REQ-018 IDLE -> INIT when init_req=1; busy goes high in the following cycle.
REQ-019 In INIT, one word per cycle: mem[i] = (INIT_BASE + i) mod 2^DATA_W, i = 0..DEPTH-1 ascending.
REQ-020 INIT -> IDLE after word DEPTH-1 is written; busy is high for exactly DEPTH cycles.
REQ-021 init_req in INIT is ignored, and the sequence does not restart.
REQ-022 init_req and en high together in IDLE: init wins; the access is dropped, with no rd_valid or addr_err.
REQ-023 en high in INIT is dropped silently and is not queued; rd_valid and addr_err stay 0.
REQ-024 Read (en=1, wr=0, addr<DEPTH): data_out = mem[addr] one cycle later; rd_valid=1 in that cycle only.
REQ-025 Write (en=1, wr=1, addr<DEPTH): mem[addr] = (mem[addr] & ~wr_mask) | (data_in & wr_mask).
REQ-026 A write leaves data_out unchanged and produces no rd_valid.
REQ-027 A read of an address written in the previous cycle returns the updated word.
REQ-028 data_out holds its last read value until the next valid read.
REQ-029 addr >= DEPTH: no memory change, no read; addr_err=1 for one cycle, one cycle after the access.
REQ-030 Back-to-back reads on consecutive cycles give rd_valid high on consecutive cycles, at full throughput.

Reset
REQ-031 rst=1 forces state=IDLE, data_out=0, rd_valid=0, busy=0, addr_err=0, init index=0, immediately and independent of clk.
REQ-032 Memory contents are not cleared by reset.
REQ-033 Reset during INIT aborts the sequence; words already preset keep their values, and the rest are unchanged.
REQ-034 After rst deasserts, the block is in IDLE and accepts an access on the first rising edge.

Structure
REQ-035 Shared package param_ram_pkg holds the state enum (IDLE, INIT) and the address-width function.
REQ-036 Sub-module param_ram_init_seq holds the init FSM and index counter, outputting busy, the write index and the preset data; the top holds the memory array and the access path.

Verification
REQ-037 Defaults, reset, then pulse init_req -> busy high for 8 cycles; reads of addr 0..7 return 2,3,4,5,6,7,8,9.
REQ-038 Write addr=3, data_in=4'hA, wr_mask=4'b0011 over preset 5 (4'b0101) -> next-cycle read of addr 3 returns 4'b0110 with rd_valid=1.
REQ-039 DEPTH=6; read addr 7 -> addr_err pulses once, rd_valid=0, data_out unchanged; write to addr 6 -> no array change.
REQ-040 init_req together with en/wr to addr 0 -> write dropped; addr 0 reads back INIT_BASE after init.
REQ-041 Assert rst after 3 init cycles -> busy=0 immediately; words 0..2 preset, words 3..7 hold their pre-init values.
REQ-042 DATA_W=4, DEPTH=16, INIT_BASE=10 -> word 6 presets to 0 (wrap), and word 15 presets to 9.
